// File: rtl/mul_share_sched_pkg.sv
// Shared types for the multiplier scheduler: M-extension op encoding and the
// tracker entry that follows each op through the multiplier pipe.
package mul_share_sched_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  // Sized for up to 4 requesters and an rd-index tag.
  localparam int TRK_ID_W  = 2;
  localparam int TRK_TAG_W = 5;

  typedef struct packed {
    logic                 vld;
    logic [TRK_ID_W-1:0]  id;
    logic [TRK_TAG_W-1:0] tag;
  } mul_trk_t;

  // Anything that is not a recognised op degrades to a plain MUL.
  function automatic logic [1:0] to_alu_op(input mul_op_t op);
    case (op)
      MUL_OP_MULH:   return 2'd1;
      MUL_OP_MULHSU: return 2'd2;
      MUL_OP_MULHU:  return 2'd3;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mul_share_sched_rr_arb.sv
// N-way round-robin arbiter: grants the first request at or after the pointer;
// the pointer moves past the winner only when the grant is consumed.
module mul_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_id;
  logic            found;
  int              idx;

  always_comb begin
    gnt_o  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) ptr_d = ID_W'((int'(gnt_id) + 1) % N_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one M-extension multiplier among N_REQ requesters: round-robin issue,
// in-flight tracking by requester/tag, stall on response backpressure, per-requester flush.
module mul_share_sched
  import mul_share_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = 1,
  parameter int TAG_W = TRK_TAG_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*2-1:0]     req_op_i,
  input  logic [N_REQ*32-1:0]    req_rs1_i,
  input  logic [N_REQ*32-1:0]    req_rs2_i,
  input  logic [N_REQ*TAG_W-1:0] req_tag_i,
  input  logic [N_REQ-1:0]       flush_i,
  output logic                   mul_en_o,
  output logic                   mul_start_o,
  output logic [1:0]             mul_op_o,
  output logic [31:0]            mul_rs1_o,
  output logic [31:0]            mul_rs2_o,
  input  logic [31:0]            mul_result_i,
  output logic [N_REQ-1:0]       resp_valid_o,
  input  logic [N_REQ-1:0]       resp_ready_i,
  output logic [31:0]            resp_data_o,
  output logic [TAG_W-1:0]       resp_tag_o,
  output logic [N_REQ-1:0]       busy_o
);

  mul_trk_t trk_q [LAT];
  mul_trk_t trk_m [LAT];
  mul_trk_t trk_d [LAT];
  mul_trk_t out_e, trk_new;

  logic [N_REQ-1:0]    gnt;
  logic                mul_en, accept, stall;
  logic [1:0]          sel_op;
  logic [31:0]         sel_rs1, sel_rs2;
  logic [TAG_W-1:0]    sel_tag;
  logic [TRK_ID_W-1:0] sel_id;

  // Flush acts in the same cycle, so every consumer looks at the masked view.
  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      trk_m[i] = trk_q[i];
      for (int r = 0; r < N_REQ; r++)
        if (trk_q[i].id == TRK_ID_W'(r) && flush_i[r]) trk_m[i].vld = 1'b0;
    end
  end

  assign out_e = trk_m[LAT-1];

  always_comb begin
    stall = 1'b0;
    for (int r = 0; r < N_REQ; r++)
      if (out_e.vld && out_e.id == TRK_ID_W'(r) && !resp_ready_i[r]) stall = 1'b1;
  end

  assign mul_en = !stall;

  mul_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req_valid_i & ~flush_i & {N_REQ{reset_n}}),
    .advance_i(mul_en),
    .gnt_o    (gnt)
  );

  assign req_ready_o = mul_en ? gnt : '0;
  assign accept      = |req_ready_o;

  // One-hot operand mux; zeros when nothing issues.
  always_comb begin
    sel_op  = '0;
    sel_rs1 = '0;
    sel_rs2 = '0;
    sel_tag = '0;
    sel_id  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (req_ready_o[r]) begin
        sel_op  = req_op_i[2*r +: 2];
        sel_rs1 = req_rs1_i[32*r +: 32];
        sel_rs2 = req_rs2_i[32*r +: 32];
        sel_tag = req_tag_i[TAG_W*r +: TAG_W];
        sel_id  = TRK_ID_W'(r);
      end
    end
  end

  assign mul_en_o    = mul_en;
  assign mul_start_o = accept;
  assign mul_op_o    = to_alu_op(mul_op_t'(sel_op));
  assign mul_rs1_o   = sel_rs1;
  assign mul_rs2_o   = sel_rs2;

  always_comb begin
    trk_new.vld = accept;
    trk_new.id  = sel_id;
    trk_new.tag = TRK_TAG_W'(sel_tag);
  end

  always_comb begin
    for (int i = 0; i < LAT; i++) trk_d[i] = trk_m[i];
    if (mul_en) begin
      trk_d[0] = trk_new;
      for (int i = 1; i < LAT; i++) trk_d[i] = trk_m[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) trk_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) trk_q[i] <= trk_d[i];
    end
  end

  always_comb begin
    resp_valid_o = '0;
    busy_o       = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (out_e.id == TRK_ID_W'(r)) resp_valid_o[r] = out_e.vld;
      for (int i = 0; i < LAT; i++)
        if (trk_m[i].vld && trk_m[i].id == TRK_ID_W'(r)) busy_o[r] = 1'b1;
    end
  end

  assign resp_data_o = mul_result_i;
  assign resp_tag_o  = TAG_W'(out_e.tag);

`ifndef SYNTHESIS
  a_op_legal: assert property (@(posedge clk) disable iff (!reset_n)
    accept |-> !$isunknown(sel_op));
`endif

endmodule
